// File: rtl/fsm_seq_player_pkg.sv
// Shared definitions for the 5-state switch sequence detector, its stimulus
// player and the benches that drive them: state codes, one-hot switch
// constants, the fixed press paths and the player FSM state type.
package fsm_pkg;

  localparam logic [2:0] S0 = 3'b000;
  localparam logic [2:0] S1 = 3'b001;
  localparam logic [2:0] S2 = 3'b010;
  localparam logic [2:0] S3 = 3'b011;
  localparam logic [2:0] S4 = 3'b100;

  localparam logic [3:0] SW1_C = 4'b0001;
  localparam logic [3:0] SW2_C = 4'b0010;
  localparam logic [3:0] SW3_C = 4'b0100;
  localparam logic [3:0] SW4_C = 4'b1000;

  typedef enum logic [2:0] {IDLE, RST, GAP, PRESS, FIN} player_state_e;

  // Number of presses needed to walk the detector from S0 to tgt.
  function automatic logic [1:0] path_len(input logic [2:0] tgt);
    case (tgt)
      S1, S3:  return 2'd1;
      S2, S4:  return 2'd2;
      default: return 2'd0;
    endcase
  endfunction

  // Switch pressed at position idx of the path towards tgt.
  function automatic logic [3:0] path_sw(input logic [2:0] tgt, input logic [1:0] idx);
    case (tgt)
      S1:      return SW1_C;
      S2:      return (idx == 2'd0) ? SW1_C : SW2_C;
      S3:      return SW3_C;
      S4:      return (idx == 2'd0) ? SW3_C : SW1_C;
      default: return 4'b0000;
    endcase
  endfunction

  // Detector state expected after the first 'presses' entries of the path.
  function automatic logic [2:0] prefix_state(input logic [2:0] tgt, input logic [1:0] presses);
    if (presses == 2'd0)             return S0;
    else if (presses >= path_len(tgt)) return tgt;
    else if (tgt == S2)              return S1;
    else if (tgt == S4)              return S3;
    else                             return tgt;
  endfunction

endpackage

// File: rtl/fsm_seq_player_timer.sv
// Loadable down-counter shared by the hold and gap phases of the player.
// A load strobe reloads the count; the counter then decrements to zero and
// parks there, with zero_o flagging the last cycle of the phase.
module seq_phase_timer #(
  parameter int W = 2
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  output logic         zero_o
);

  logic [W-1:0] cnt_q;

  // Reload on phase entry, otherwise count down and hold at zero.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)               cnt_q <= '0;
    else if (load_i)         cnt_q <= load_val_i;
    else if (cnt_q != '0)    cnt_q <= cnt_q - W'(1);
  end

  assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/fsm_seq_player.sv
// Stimulus player for the switch-driven 5-state sequence detector.
// On start it pulses det_reset, then presses the minimal one-hot switch path
// from S0 to the requested target, with all-low gaps between pulses.
// All outputs are registered so they can drive the detector directly.
// Optional feature macro: FSM_SEQ_PLAYER_CHECK_EN adds det_state/mismatch,
// comparing the detector state at the end of every gap.
module fsm_seq_player
  import fsm_pkg::*;
#(
  parameter int HOLD_CYCLES = 4,
  parameter int GAP_CYCLES  = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [2:0] target,
  output logic       det_reset,
  output logic [3:0] sw,
  output logic       busy,
  output logic       done,
  output logic       err
`ifdef FSM_SEQ_PLAYER_CHECK_EN
  ,
  input  logic [2:0] det_state,
  output logic       mismatch
`endif
);

  localparam int MAX_C = (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
  localparam int TW    = $clog2(MAX_C + 1);
  localparam logic [TW-1:0] HOLD_LD = TW'(HOLD_CYCLES - 1);
  localparam logic [TW-1:0] GAP_LD  = TW'(GAP_CYCLES - 1);

  player_state_e state_q, state_d;
  logic [2:0]    tgt_q, tgt_d;
  logic [1:0]    idx_q, idx_d;
  logic          ld;
  logic [TW-1:0] ld_val;
  logic          tmr_zero;
  logic          err_d;
  logic [3:0]    sw_d;
  logic          det_reset_q, busy_q, done_q, err_q;
  logic [3:0]    sw_q;

  seq_phase_timer #(.W(TW)) u_timer (
    .clk        (clk),
    .reset      (reset),
    .load_i     (ld),
    .load_val_i (ld_val),
    .zero_o     (tmr_zero)
  );

  // Next-state logic: each phase reloads the timer on entry and leaves when
  // the timer reaches zero; the press index advances as a press ends.
  always_comb begin
    state_d = state_q;
    tgt_d   = tgt_q;
    idx_d   = idx_q;
    ld      = 1'b0;
    ld_val  = HOLD_LD;
    err_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          if (target <= S4) begin
            state_d = RST;
            tgt_d   = target;
            idx_d   = 2'd0;
            ld      = 1'b1;
            ld_val  = HOLD_LD;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      RST: begin
        if (tmr_zero) begin
          state_d = GAP;
          ld      = 1'b1;
          ld_val  = GAP_LD;
        end
      end
      GAP: begin
        if (tmr_zero) begin
          if (idx_q < path_len(tgt_q)) begin
            state_d = PRESS;
            ld      = 1'b1;
            ld_val  = HOLD_LD;
          end else begin
            state_d = FIN;
          end
        end
      end
      PRESS: begin
        if (tmr_zero) begin
          state_d = GAP;
          idx_d   = idx_q + 2'd1;
          ld      = 1'b1;
          ld_val  = GAP_LD;
        end
      end
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
    sw_d = (state_d == PRESS) ? path_sw(tgt_d, idx_d) : 4'b0000;
  end

  // State register plus output registers decoded from the next state, so
  // every output changes on the same edge as the phase it belongs to.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      tgt_q       <= S0;
      idx_q       <= 2'd0;
      det_reset_q <= 1'b0;
      sw_q        <= 4'b0000;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      tgt_q       <= tgt_d;
      idx_q       <= idx_d;
      det_reset_q <= (state_d == RST);
      sw_q        <= sw_d;
      busy_q      <= (state_d == RST) || (state_d == GAP) || (state_d == PRESS);
      done_q      <= (state_d == FIN);
      err_q       <= err_d;
    end
  end

  assign det_reset = det_reset_q;
  assign sw        = sw_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign err       = err_q;

`ifdef FSM_SEQ_PLAYER_CHECK_EN
  logic mismatch_q;

  // Sticky detector-state check in the last gap cycle after each pulse;
  // cleared by an accepted start.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      mismatch_q <= 1'b0;
    else if ((state_q == IDLE) && start && (target <= S4))
      mismatch_q <= 1'b0;
    else if ((state_q == GAP) && tmr_zero && (det_state != prefix_state(tgt_q, idx_q)))
      mismatch_q <= 1'b1;
  end

  assign mismatch = mismatch_q;
`endif

endmodule

// File: tb/tb_fsm_seq_player.sv
// Directed bench for fsm_seq_player with HOLD_CYCLES=2, GAP_CYCLES=1.
// Expected per-cycle outputs are hand-written tables packed as
// {det_reset, sw[3:0], busy, done, err}; cycle 1 is the cycle after the
// clock edge that samples start.
module tb_fsm_seq_player;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic [2:0] target;
  logic       det_reset;
  logic [3:0] sw;
  logic       busy, done, err;
`ifdef FSM_SEQ_PLAYER_CHECK_EN
  logic       mismatch;
`endif

  int checks = 0;
  int errors = 0;

  localparam logic [7:0] I  = 8'b0_0000_0_0_0;
  localparam logic [7:0] D  = 8'b1_0000_1_0_0;
  localparam logic [7:0] G  = 8'b0_0000_1_0_0;
  localparam logic [7:0] P1 = 8'b0_0001_1_0_0;
  localparam logic [7:0] P2 = 8'b0_0010_1_0_0;
  localparam logic [7:0] P3 = 8'b0_0100_1_0_0;
  localparam logic [7:0] FN = 8'b0_0000_0_1_0;
  localparam logic [7:0] E  = 8'b0_0000_0_0_1;

  logic [7:0] exp_tbl [1:11];

  fsm_seq_player #(.HOLD_CYCLES(2), .GAP_CYCLES(1)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .target    (target),
    .det_reset (det_reset),
    .sw        (sw),
    .busy      (busy),
    .done      (done),
    .err       (err)
`ifdef FSM_SEQ_PLAYER_CHECK_EN
    ,
    .det_state (3'b000),
    .mismatch  (mismatch)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input int cyc, input logic [7:0] expv);
    logic [7:0] obs;
    obs = {det_reset, sw, busy, done, err};
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s cycle %0d: observed %b expected %b", tag, cyc, obs, expv);
    end
  endtask

  // Issue start with tgt in the current cycle, then check cycles 1..n.
  // At cycle inj (if nonzero) a second start with target 3 is presented.
  task automatic play(input string tag, input logic [2:0] tgt, input int n, input int inj);
    start  = 1'b1;
    target = tgt;
    step();
    start  = 1'b0;
    for (int c = 1; c <= n; c++) begin
      chk(tag, c, exp_tbl[c]);
      if (c == inj) begin
        start  = 1'b1;
        target = 3'd3;
      end
      if (c < n) step();
      start = 1'b0;
    end
  endtask

  initial begin
    reset  = 1'b1;
    start  = 1'b0;
    target = 3'd0;
    step();
    step();
    chk("reset_hold", 0, I);
    reset = 1'b0;
    step();
    chk("after_reset", 0, I);

    exp_tbl = '{D, D, G, P3, P3, G, P1, P1, G, FN, I};
    play("t4", 3'd4, 11, 0);

    exp_tbl = '{D, D, G, FN, I, I, I, I, I, I, I};
    play("t0", 3'd0, 5, 0);

    exp_tbl = '{E, I, I, I, I, I, I, I, I, I, I};
    play("t6_invalid", 3'd6, 2, 0);

    exp_tbl = '{D, D, G, P1, P1, G, FN, I, I, I, I};
    play("t1", 3'd1, 8, 0);

    exp_tbl = '{D, D, G, P1, P1, G, P2, P2, G, FN, I};
    play("t2_busy_start", 3'd2, 11, 5);

    exp_tbl = '{D, D, G, P3, P3, G, P1, P1, G, FN, I};
    play("t4_pre_reset", 3'd4, 5, 0);
    reset = 1'b1;
    #1;
    chk("async_reset", 5, I);
    start  = 1'b1;
    target = 3'd4;
    step();
    chk("reset_wins", 6, I);
    reset = 1'b0;
    play("t4_replay", 3'd4, 11, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
